// File: rtl/opendap_swj_link_monitor.sv
// SWJ link-state monitor: selection alert, activation codes, SWD line reset and dormant select.
// Define OPENDAP_SWJ_JTAG_SELECT_EN to build the JTAG activation and JTAG-to-dormant path.
module opendap_swj_link_monitor #(
  parameter int unsigned RESET_HIGH_CYCLES = 50,
  parameter int unsigned RESET_IN_DORMANT  = 1,
  parameter logic [7:0]  ACT_CODE_SWD      = 8'b0101_1000,
  parameter logic [11:0] ACT_CODE_JTAG     = 12'h000,
  parameter logic [15:0] SELECT_S2D        = 16'b0011_1101_1100_0111,
  parameter logic [30:0] SELECT_J2D        = 31'h33BB_BBBA
) (
  input  logic       swclk,
  input  logic       rst_n,
  input  logic       swdi_reg,
  output logic [1:0] link_state,
  output logic       exit_dormant,
  output logic       enter_dormant,
  output logic       line_reset
);

  typedef enum logic [3:0] {
    StDormantStart = 4'd0,
    StAlert        = 4'd1,
    StPostAlert    = 4'd2,
    StActCode      = 4'd3,
    StS2dResetHigh = 4'd4,
    StS2dResetLow1 = 4'd5,
    StS2dResetLow2 = 4'd6,
    StS2dSelect    = 4'd7,
    StJ2dTlr       = 4'd8,
    StJ2dSelect    = 4'd9
  } state_e;

  localparam logic [6:0] LfsrInit  = 7'b1001001;
  localparam logic [6:0] LfsrTaps  = 7'b1001011;
  localparam logic [5:0] ResetLoad = 6'(RESET_HIGH_CYCLES);
  localparam state_e     ResetState = (RESET_IN_DORMANT != 0) ? StDormantStart : StS2dResetHigh;
  localparam logic [1:0] ResetLink  = (RESET_IN_DORMANT != 0) ? 2'd0 : 2'd1;
`ifdef OPENDAP_SWJ_JTAG_SELECT_EN
  localparam bit JtagEn = 1'b1;
`else
  localparam bit JtagEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [1:0] link_q, link_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] bit_cnt_q, bit_cnt_d;
  logic [5:0] rst_cnt_q, rst_cnt_d;
  logic       swd_ok_q, swd_ok_d;
  logic       jtag_ok_q, jtag_ok_d;

  logic       alert_match;
  logic [3:0] act_idx;
  logic       swd_live, jtag_live;
  logic       sel_bit;
  logic       in_swd;

  assign alert_match = (swdi_reg == lfsr_q[0]);
  assign act_idx     = bit_cnt_q[3:0];
  // SWD code is 8 bits, so the SWD candidate dies once the index passes bit 7.
  assign swd_live    = swd_ok_q && !act_idx[3] && (swdi_reg == ACT_CODE_SWD[~act_idx[2:0]]);
  assign jtag_live   = jtag_ok_q && (swdi_reg == ACT_CODE_JTAG[4'd11 - act_idx]);
  assign sel_bit     = (state_q == StJ2dSelect) ? SELECT_J2D[bit_cnt_q[4:0]]
                                                : SELECT_S2D[bit_cnt_q[3:0]];
  assign in_swd      = (state_q == StS2dResetHigh) || (state_q == StS2dResetLow1) ||
                       (state_q == StS2dResetLow2) || (state_q == StS2dSelect);

  always_comb begin
    lfsr_d = LfsrInit;
    if ((state_q == StAlert) && alert_match) begin
      lfsr_d = {^(lfsr_q & LfsrTaps), lfsr_q[6:1]};
    end
  end

  // Counts remaining 1s needed for a line reset; held at the reload value outside SWD.
  always_comb begin
    rst_cnt_d = ResetLoad;
    if (in_swd && swdi_reg) begin
      rst_cnt_d = (rst_cnt_q == 6'd0) ? 6'd0 : rst_cnt_q - 6'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    swd_ok_d      = swd_ok_q;
    jtag_ok_d     = jtag_ok_q;
    exit_dormant  = 1'b0;
    enter_dormant = 1'b0;
    line_reset    = 1'b0;
    case (state_q)
      StDormantStart: begin
        if (!swdi_reg) begin
          state_d   = StAlert;
          bit_cnt_d = 7'd126;
        end
      end
      StAlert: begin
        if (alert_match) begin
          if (bit_cnt_q == 7'd0) begin
            state_d   = StPostAlert;
            bit_cnt_d = 7'd3;
          end else begin
            bit_cnt_d = bit_cnt_q - 7'd1;
          end
        end else if (swdi_reg) begin
          state_d = StDormantStart;
        end else begin
          bit_cnt_d = 7'd126;
        end
      end
      StPostAlert: begin
        if (bit_cnt_q == 7'd0) begin
          state_d   = StActCode;
          bit_cnt_d = 7'd0;
          swd_ok_d  = 1'b1;
          jtag_ok_d = JtagEn;
        end else begin
          bit_cnt_d = bit_cnt_q - 7'd1;
        end
      end
      StActCode: begin
        swd_ok_d  = swd_live;
        jtag_ok_d = jtag_live;
        bit_cnt_d = bit_cnt_q + 7'd1;
        if (swd_live && (act_idx == 4'd7)) begin
          exit_dormant = 1'b1;
          state_d      = StS2dResetHigh;
`ifdef OPENDAP_SWJ_JTAG_SELECT_EN
        end else if (jtag_live && (act_idx == 4'd11)) begin
          exit_dormant = 1'b1;
          state_d      = StJ2dTlr;
          bit_cnt_d    = 7'd0;
`endif
        end else if (!swd_live && !jtag_live) begin
          // A failing 0 may itself be the first bit of a fresh alert.
          state_d   = swdi_reg ? StDormantStart : StAlert;
          bit_cnt_d = 7'd126;
        end
      end
      StS2dResetHigh: begin
        if (swdi_reg && (rst_cnt_q <= 6'd1)) state_d = StS2dResetLow1;
      end
      StS2dResetLow1: begin
        if (!swdi_reg) state_d = StS2dResetLow2;
      end
      StS2dResetLow2: begin
        if (!swdi_reg) begin
          line_reset = 1'b1;
          state_d    = StS2dSelect;
          bit_cnt_d  = 7'd13;
        end else begin
          state_d = StS2dResetHigh;
        end
      end
      StS2dSelect: begin
        if (swdi_reg == sel_bit) begin
          if (bit_cnt_q == 7'd0) begin
            enter_dormant = 1'b1;
            state_d       = StDormantStart;
          end else begin
            bit_cnt_d = bit_cnt_q - 7'd1;
          end
        end else begin
          state_d = StS2dResetHigh;
        end
      end
`ifdef OPENDAP_SWJ_JTAG_SELECT_EN
      StJ2dTlr: begin
        if (swdi_reg) begin
          if (bit_cnt_q < 7'd5) bit_cnt_d = bit_cnt_q + 7'd1;
        end else if (bit_cnt_q >= 7'd5) begin
          state_d   = StJ2dSelect;
          bit_cnt_d = 7'd1;
        end else begin
          bit_cnt_d = 7'd0;
        end
      end
      StJ2dSelect: begin
        if (swdi_reg == sel_bit) begin
          if (bit_cnt_q == 7'd30) begin
            enter_dormant = 1'b1;
            state_d       = StDormantStart;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end else begin
          state_d   = StJ2dTlr;
          bit_cnt_d = {6'd0, swdi_reg};
        end
      end
`endif
      default: state_d = StDormantStart;
    endcase
  end

  always_comb begin
    link_d = 2'd0;
    case (state_d)
      StS2dResetHigh, StS2dResetLow1, StS2dResetLow2, StS2dSelect: link_d = 2'd1;
`ifdef OPENDAP_SWJ_JTAG_SELECT_EN
      StJ2dTlr, StJ2dSelect: link_d = 2'd2;
`endif
      default: link_d = 2'd0;
    endcase
  end

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ResetState;
      link_q    <= ResetLink;
      lfsr_q    <= LfsrInit;
      bit_cnt_q <= '0;
      rst_cnt_q <= '0;
      swd_ok_q  <= 1'b0;
      jtag_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      link_q    <= link_d;
      lfsr_q    <= lfsr_d;
      bit_cnt_q <= bit_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      swd_ok_q  <= swd_ok_d;
      jtag_ok_q <= jtag_ok_d;
    end
  end

  assign link_state = link_q;

endmodule
